// File: rtl/gr_access_ctrl.sv
// gr_access_ctrl: initiator side of the general-register file ports.
// This block sits between decode and execute. It drives the register-file
// read strobes, keeps a busy scoreboard for RAW hazards, and registers the
// operands handed to execute. It also turns writeback commits into
// register-file writes.
// Optional feature: define GR_BYPASS_EN to forward same-cycle writeback data
// into the operand register. This removes the one-cycle bubble after writeback.
module gr_access_ctrl #(
  parameter int STALL_W = 16
) (
  input  logic               m_clock,
  input  logic               p_reset,
  input  logic               iss_valid,
  output logic               iss_ready,
  input  logic [4:0]         iss_rs1,
  input  logic [4:0]         iss_rs2,
  input  logic               iss_use1,
  input  logic               iss_use2,
  input  logic [4:0]         iss_rd,
  input  logic               iss_wen,
  output logic               rs1,
  output logic [4:0]         rs1_n,
  output logic               rs2,
  output logic [4:0]         rs2_n,
  input  logic [31:0]        s1_rd,
  input  logic [31:0]        s2_rd,
  output logic               rd,
  output logic [4:0]         rd_n,
  output logic [31:0]        wd,
  input  logic               wb_valid,
  input  logic [4:0]         wb_rd,
  input  logic [31:0]        wb_data,
  output logic               op_valid,
  input  logic               op_ready,
  output logic [31:0]        op_a,
  output logic [31:0]        op_b,
  output logic [4:0]         op_rd,
  output logic               op_wen,
  output logic [STALL_W-1:0] stall_cnt
);

  typedef enum logic {
    OP_EMPTY = 1'b0,
    OP_FULL  = 1'b1
  } op_state_e;

  op_state_e          op_state_q;
  logic [31:0]        op_a_q;
  logic [31:0]        op_b_q;
  logic [4:0]         op_rd_q;
  logic               op_wen_q;
  logic [31:0]        busy_q;
  logic [31:0]        busy_d;
  logic [STALL_W-1:0] stall_q;
  logic [STALL_W-1:0] stall_d;

  logic               wb_act;
  logic               fwd1;
  logic               fwd2;
  logic               haz;
  logic               accept;
  logic [31:0]        src_a;
  logic [31:0]        src_b;

  // A writeback to x0 is architecturally meaningless and is never issued to the file
  assign wb_act = wb_valid & (wb_rd != 5'd0);

`ifdef GR_BYPASS_EN
  assign fwd1 = wb_act & (wb_rd == iss_rs1) & iss_use1;
  assign fwd2 = wb_act & (wb_rd == iss_rs2) & iss_use2;
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  // A forwarded source is satisfied this cycle even though its busy bit is still set
  assign haz = (iss_use1 & busy_q[iss_rs1] & ~fwd1) |
               (iss_use2 & busy_q[iss_rs2] & ~fwd2);

  assign op_valid  = (op_state_q == OP_FULL);
  assign iss_ready = (~op_valid | op_ready) & ~haz;
  assign accept    = iss_valid & iss_ready;

  assign rs1   = iss_valid & iss_use1;
  assign rs1_n = iss_rs1;
  assign rs2   = iss_valid & iss_use2;
  assign rs2_n = iss_rs2;

  // The write strobe is gated by reset so that no stale commit reaches the file
  assign rd   = ~p_reset & wb_act;
  assign rd_n = wb_rd;
  assign wd   = wb_data;

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign op_rd     = op_rd_q;
  assign op_wen    = op_wen_q;
  assign stall_cnt = stall_q;

  // Select operand sources: unused sources read as zero, forwarded ones take wb_data
  always_comb begin
    src_a = 32'd0;
    src_b = 32'd0;
    if (iss_use1) begin
      src_a = fwd1 ? wb_data : s1_rd;
    end else begin
      src_a = 32'd0;
    end
    if (iss_use2) begin
      src_b = fwd2 ? wb_data : s2_rd;
    end else begin
      src_b = 32'd0;
    end
  end

  // Scoreboard next state: clear on writeback first so a same-cycle set wins
  always_comb begin
    busy_d = busy_q;
    if (wb_act) begin
      busy_d[wb_rd] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (accept & iss_wen & (iss_rd != 5'd0)) begin
      busy_d[iss_rd] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;
  end

  // Stall counter next state: count hazard-blocked issue cycles, saturating
  always_comb begin
    stall_d = stall_q;
    if (iss_valid & haz & ~(&stall_q)) begin
      stall_d = stall_q + {{(STALL_W-1){1'b0}}, 1'b1};
    end else begin
      stall_d = stall_q;
    end
  end

  // Scoreboard and stall counter registers
  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      busy_q  <= 32'd0;
      stall_q <= {STALL_W{1'b0}};
    end else begin
      busy_q  <= busy_d;
      stall_q <= stall_d;
    end
  end

  // Operand register FSM: capture on accept, drain on op_ready, hold otherwise
  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      op_state_q <= OP_EMPTY;
      op_a_q     <= 32'd0;
      op_b_q     <= 32'd0;
      op_rd_q    <= 5'd0;
      op_wen_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_state_q <= OP_FULL;
        op_a_q     <= src_a;
        op_b_q     <= src_b;
        op_rd_q    <= iss_rd;
        op_wen_q   <= iss_wen;
      end else begin
        case (op_state_q)
          OP_EMPTY: op_state_q <= OP_EMPTY;
          OP_FULL:  op_state_q <= op_ready ? OP_EMPTY : OP_FULL;
          default:  op_state_q <= OP_EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gr_access_ctrl.sv
// Self-checking bench for gr_access_ctrl: a reference model computes
// expected handshakes and operands. Expected operand bundles are queued at
// issue acceptance and compared while the operand register is full.
module tb_gr_access_ctrl;
  localparam int STALL_W = 16;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        wen;
  } op_t;

  logic               m_clock = 1'b0;
  logic               p_reset;
  logic               iss_valid, iss_ready;
  logic [4:0]         iss_rs1, iss_rs2, iss_rd;
  logic               iss_use1, iss_use2, iss_wen;
  logic               rs1, rs2, rd;
  logic [4:0]         rs1_n, rs2_n, rd_n;
  logic [31:0]        s1_rd, s2_rd, wd;
  logic               wb_valid;
  logic [4:0]         wb_rd;
  logic [31:0]        wb_data;
  logic               op_valid, op_ready, op_wen;
  logic [31:0]        op_a, op_b;
  logic [4:0]         op_rd;
  logic [STALL_W-1:0] stall_cnt;

  logic [31:0]        regs [32];
  assign s1_rd = regs[rs1_n];
  assign s2_rd = regs[rs2_n];

  always #5 m_clock = ~m_clock;

  gr_access_ctrl #(.STALL_W(STALL_W)) dut (
    .m_clock(m_clock), .p_reset(p_reset),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_use1(iss_use1), .iss_use2(iss_use2),
    .iss_rd(iss_rd), .iss_wen(iss_wen),
    .rs1(rs1), .rs1_n(rs1_n), .rs2(rs2), .rs2_n(rs2_n),
    .s1_rd(s1_rd), .s2_rd(s2_rd),
    .rd(rd), .rd_n(rd_n), .wd(wd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_rd(op_rd), .op_wen(op_wen),
    .stall_cnt(stall_cnt)
  );

  int                 total = 0;
  int                 bad = 0;
  logic [31:0]        m_busy = 32'd0;
  logic               m_opv = 1'b0;
  logic [STALL_W-1:0] m_stall = '0;
  logic               last_acc = 1'b0;
  op_t                exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic iss(input logic [4:0] r1, input logic [4:0] r2, input logic u1,
                     input logic u2, input logic [4:0] rdn, input logic wen);
    iss_valid = 1'b1; iss_rs1 = r1; iss_rs2 = r2; iss_use1 = u1; iss_use2 = u2;
    iss_rd = rdn; iss_wen = wen;
  endtask

  task automatic wb(input logic v, input logic [4:0] r, input logic [31:0] d);
    wb_valid = v; wb_rd = r; wb_data = d;
  endtask

  // One clock: check combinational and registered outputs, advance the model
  task automatic tick();
    logic wa, f1, f2, h, rdy, acc;
    op_t  e;
    #1;
    wa = wb_valid & (wb_rd != 5'd0);
`ifdef GR_BYPASS_EN
    f1 = wa & (wb_rd == iss_rs1) & iss_use1;
    f2 = wa & (wb_rd == iss_rs2) & iss_use2;
`else
    f1 = 1'b0;
    f2 = 1'b0;
`endif
    h   = (iss_use1 & m_busy[iss_rs1] & ~f1) | (iss_use2 & m_busy[iss_rs2] & ~f2);
    rdy = (~m_opv | op_ready) & ~h;
    acc = iss_valid & rdy & ~p_reset;
    chk("rd_ports", {rs1, rs1_n, rs2, rs2_n},
        {iss_valid & iss_use1, iss_rs1, iss_valid & iss_use2, iss_rs2});
    chk("wr_strobe", rd, wa & ~p_reset);
    if (wa) chk("wr_addr_data", {rd_n, wd}, {wb_rd, wb_data});
    if (!p_reset) begin
      chk("iss_ready", iss_ready, rdy);
      chk("op_valid", op_valid, m_opv);
      chk("stall_cnt", stall_cnt, m_stall);
      if (m_opv && exp_q.size() > 0) begin
        e = exp_q[0];
        chk("op_bundle", {op_a, op_b, op_rd, op_wen}, e);
      end
    end
    if (p_reset) begin
      m_busy = 32'd0; m_opv = 1'b0; m_stall = '0; exp_q.delete();
    end else begin
      if (m_opv && op_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc) begin
        e.a   = iss_use1 ? (f1 ? wb_data : regs[iss_rs1]) : 32'd0;
        e.b   = iss_use2 ? (f2 ? wb_data : regs[iss_rs2]) : 32'd0;
        e.rd  = iss_rd;
        e.wen = iss_wen;
        exp_q.push_back(e);
      end
      m_opv = acc | (m_opv & ~op_ready);
      if (wa) m_busy[wb_rd] = 1'b0;
      if (acc && iss_wen && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
      if (iss_valid && h && m_stall != {STALL_W{1'b1}}) m_stall = m_stall + 1'b1;
    end
    last_acc = acc;
    @(posedge m_clock);
    #1;
    if (wa && !p_reset) regs[wb_rd] = wb_data;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000 + i;
    regs[0] = 32'd0;
    p_reset = 1'b1; op_ready = 1'b1;
    iss(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0); iss_valid = 1'b0;
    wb(1'b1, 5'd3, 32'h55);
    tick(); tick();
    p_reset = 1'b0; wb(1'b0, 5'd0, 32'd0);
    chk("rst_op", {op_valid, op_a, op_b, op_rd, op_wen}, 71'd0);
    chk("rst_stall", stall_cnt, 16'd0);

    // Writeback to non-busy registers
    wb(1'b1, 5'd5, 32'hDEADBEEF);
    #1 chk("wb_strobe", {rd, rd_n, wd}, {1'b1, 5'd5, 32'hDEADBEEF});
    tick();
    chk("wb_no_op", op_valid, 1'b0);
    wb(1'b1, 5'd5, 32'h11); tick();
    wb(1'b1, 5'd6, 32'h22); tick();
    wb(1'b0, 5'd0, 32'd0);

    // Basic issue, one-cycle latency
    iss(5'd5, 5'd6, 1'b1, 1'b1, 5'd7, 1'b1); tick();
    chk("t2_acc", last_acc, 1'b1);
    chk("t2_op", {op_valid, op_a, op_b, op_rd}, {1'b1, 32'h11, 32'h22, 5'd7});

    // RAW hazard on x7, resolved by writeback
    iss(5'd7, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1);
    tick(); tick(); tick();
    chk("t3_stall3", stall_cnt, 16'd3);
    wb(1'b1, 5'd7, 32'hCAFE0007); tick();
`ifdef GR_BYPASS_EN
    chk("t3_same_cycle_acc", last_acc, 1'b1);
    wb(1'b0, 5'd0, 32'd0);
`else
    chk("t3_same_cycle_acc", last_acc, 1'b0);
    wb(1'b0, 5'd0, 32'd0);
    tick();
    chk("t3_next_cycle_acc", last_acc, 1'b1);
`endif
    chk("t3_op_a", op_a, 32'hCAFE0007);
    iss_valid = 1'b0; tick();

    // Backpressure hold, then back-to-back issue
    iss(5'd1, 5'd2, 1'b1, 1'b1, 5'd10, 1'b1); tick();
    op_ready = 1'b0;
    iss(5'd3, 5'd4, 1'b1, 1'b1, 5'd11, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_held_no_acc", last_acc, 1'b0);
    end
    chk("t4_held_op", {op_a, op_b, op_rd}, {32'h1001, 32'h1002, 5'd10});
    op_ready = 1'b1; tick();
    chk("t4_b2b_acc1", last_acc, 1'b1);
    iss(5'd12, 5'd13, 1'b1, 1'b0, 5'd14, 1'b0); tick();
    chk("t4_b2b_acc2", last_acc, 1'b1);
    iss_valid = 1'b0; tick();

    // x0 never becomes busy and is never written
    iss(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1); tick();
    iss(5'd0, 5'd0, 1'b1, 1'b1, 5'd12, 1'b0); tick();
    chk("t5_x0_acc", last_acc, 1'b1);
    chk("t5_x0_op", {op_a, op_b}, 64'd0);
    iss_valid = 1'b0; wb(1'b1, 5'd0, 32'h1234);
    #1 chk("t5_rd0", rd, 1'b0);
    tick();
    wb(1'b0, 5'd0, 32'd0);

    // Same-cycle set/clear of x9: set wins; then saturate stall counter
    wb(1'b1, 5'd9, 32'h99);
    iss(5'd13, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1); tick();
    chk("t6_acc", last_acc, 1'b1);
    wb(1'b0, 5'd0, 32'd0);
    iss(5'd9, 5'd0, 1'b1, 1'b0, 5'd15, 1'b0);
    for (int i = 0; i < (1 << STALL_W) + 5; i++) tick();
    chk("t6_busy9_stalls", last_acc, 1'b0);
    chk("t6_saturated", stall_cnt, {STALL_W{1'b1}});

    // Mid-operation reset discards busy bits and operand register
    op_ready = 1'b0;
    iss(5'd15, 5'd0, 1'b0, 1'b0, 5'd16, 1'b1); tick();
    chk("t7_pre_acc", last_acc, 1'b1);
    p_reset = 1'b1; tick();
    p_reset = 1'b0; op_ready = 1'b1;
    chk("t7_rst", {op_valid, stall_cnt}, 17'd0);
    iss(5'd9, 5'd0, 1'b1, 1'b0, 5'd15, 1'b0); tick();
    chk("t7_reissue_acc", last_acc, 1'b1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      iss_valid = $urandom_range(0, 3) != 0;
      iss_rs1 = 5'($urandom_range(0, 7)); iss_rs2 = 5'($urandom_range(0, 7));
      iss_use1 = 1'($urandom); iss_use2 = 1'($urandom);
      iss_rd = 5'($urandom_range(0, 7)); iss_wen = 1'($urandom);
      op_ready = $urandom_range(0, 3) != 0;
      wb(1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gr_access_ctrl.md
Name: gr_access_ctrl

Overview:
- Initiator side of the general-register file port set. Drives the read strobes `rs1`/`rs2` with addresses `rs1_n`/`rs2_n`, consumes `s1_rd`/`s2_rd`, and drives the write strobe `rd` with `rd_n`/`wd`.
- Sits between decode and execute. Accepts decoded register references, holds a busy scoreboard for RAW hazards, registers operands for execute, and turns writeback commits into register-file writes.

Parameters:
- STALL_W, 16, width of the saturating hazard-stall counter.

Ports:
- m_clock  in  1  clock; all state updates on rising edge
- p_reset  in  1  synchronous active-high reset
- iss_valid  in  1  decoded instruction present
- iss_ready  out  1  instruction accepted this cycle when high with iss_valid
- iss_rs1  in  5  source 1 register number
- iss_rs2  in  5  source 2 register number
- iss_use1  in  1  source 1 needed
- iss_use2  in  1  source 2 needed
- iss_rd  in  5  destination register number
- iss_wen  in  1  instruction writes a destination
- rs1  out  1  register-file read strobe, port 1
- rs1_n  out  5  register-file read address, port 1
- rs2  out  1  register-file read strobe, port 2
- rs2_n  out  5  register-file read address, port 2
- s1_rd  in  32  register-file read data, port 1 (combinational)
- s2_rd  in  32  register-file read data, port 2 (combinational)
- rd  out  1  register-file write strobe
- rd_n  out  5  register-file write address
- wd  out  32  register-file write data
- wb_valid  in  1  writeback commit
- wb_rd  in  5  writeback register number
- wb_data  in  32  writeback data
- op_valid  out  1  operand register full
- op_ready  in  1  execute consumes operands
- op_a  out  32  operand 1
- op_b  out  32  operand 2
- op_rd  out  5  destination passed to execute
- op_wen  out  1  destination write flag passed to execute
- stall_cnt  out  STALL_W  count of hazard-stall cycles

Behaviour:
- Reset:
  - busy[31:0]=0, op_valid=0, op_a=op_b=0, op_rd=0, op_wen=0, stall_cnt=0.
  - rd is forced to 0 while p_reset is high.
- Read port, combinational:
  - rs1 = iss_valid & iss_use1, and rs1_n = iss_rs1.
  - rs2 = iss_valid & iss_use2, and rs2_n = iss_rs2.
- Hazard, combinational:
  - haz = (iss_use1 & busy[iss_rs1]) | (iss_use2 & busy[iss_rs2]).
  - busy[0] is never set.
- Ready and accept:
  - iss_ready = (~op_valid | op_ready) & ~haz.
  - Accept = iss_valid & iss_ready.
- Operand register, two states EMPTY (op_valid=0) and FULL (op_valid=1):
  - On accept: FULL. op_a = iss_use1 ? s1_rd : 0, op_b = iss_use2 ? s2_rd : 0; op_rd and op_wen are captured. Latency from accept to op_valid is 1 cycle.
  - FULL & op_ready & no accept: EMPTY.
  - FULL & ~op_ready: all op_* held stable.
- Scoreboard:
  - On accept with iss_wen & iss_rd!=0, set busy[iss_rd].
  - On wb_valid with wb_rd!=0, clear busy[wb_rd].
  - Same bit set and cleared in the same cycle: set wins.
  - Writeback to a register that is not busy: write still performed, busy unchanged.
- Write port, combinational:
  - rd = wb_valid & (wb_rd!=0), rd_n = wb_rd, wd = wb_data.
  - The register file updates at the same edge, so a same-cycle read returns the old value. Without bypass, haz therefore stays high for that cycle.
- Stall counter:
  - Increments when iss_valid & haz.
  - Saturates at all-ones and never wraps.
- Mid-operation reset: all pending busy bits and the operand register are discarded. The issuing stage re-presents its instruction.

Optional Feature:
- Macro GR_BYPASS_EN.
- Defined:
  - When wb_valid & wb_rd!=0 & wb_rd==iss_rs1 & iss_use1, op_a captures wb_data instead of s1_rd; same rule for iss_rs2/op_b.
  - Such a source is excluded from haz even though its busy bit is set, so a same-cycle writeback releases the stall with no bubble.
- Undefined: no forwarding. haz follows the formula above, giving a one-cycle stall after writeback.

Test Plan:
- Reset then wb_valid=1, wb_rd=5, wb_data=0xDEADBEEF -> same cycle rd=1, rd_n=5, wd=0xDEADBEEF; busy stays 0; op_valid=0.
- Issue rs1=5, rs2=6, rd=7, wen=1, op_ready=1 with regfile returning 0x11/0x22 -> next cycle op_valid=1, op_a=0x11, op_b=0x22, op_rd=7.
- Following issue reading x7 -> iss_ready=0 and stall_cnt increments each cycle; wb_rd=7 arrives. Without GR_BYPASS_EN: accepted the cycle after. With it: accepted the same cycle with op_a=wb_data.
- op_ready=0 with op_valid=1 -> op_a/op_b/op_rd held, iss_ready=0 for 10 cycles, no scoreboard change; op_ready=1 -> drains and a new issue is accepted back-to-back.
- Issue with iss_rd=0, wen=1, then read x0 -> no stall, op_a=0; wb_rd=0 -> rd=0.
- Same-cycle writeback x9 and issue with rd=9 -> busy[9]=1 after the edge. Hold iss_valid & haz for 2^STALL_W+5 cycles -> stall_cnt=all-ones.
